// File: rtl/seq_match_pkg.sv
`default_nettype none
// ============================================================================
// Package    : seq_match_pkg
// Description: Shared constants for the serial sequence match counter:
//              BCD digit width, 7-segment codes {a,b,c,d,e,f,g} (active high)
//              and a single-digit BCD increment helper.
// Revision   : 1.0 - initial release
// ============================================================================
package seq_match_pkg;

  // Width of one BCD digit
  localparam int c_bcd_w = 4;

  // 7-segment codes, segment a is the MSB
  localparam logic [6:0] c_seg_0     = 7'b1111110;
  localparam logic [6:0] c_seg_1     = 7'b0110000;
  localparam logic [6:0] c_seg_2     = 7'b1101101;
  localparam logic [6:0] c_seg_3     = 7'b1111001;
  localparam logic [6:0] c_seg_4     = 7'b0110011;
  localparam logic [6:0] c_seg_5     = 7'b1011011;
  localparam logic [6:0] c_seg_6     = 7'b1011111;
  localparam logic [6:0] c_seg_7     = 7'b1110000;
  localparam logic [6:0] c_seg_8     = 7'b1111111;
  localparam logic [6:0] c_seg_9     = 7'b1110011;
  localparam logic [6:0] c_seg_blank = 7'b0000000;

  // Add a carry-in to one BCD digit; returns {carry_out, digit}.
  // Any digit at or above 9 rolls to 0 with a carry so the digit never
  // leaves the 0..9 range.
  function automatic logic [c_bcd_w:0] bcd_digit_inc(
    input logic [c_bcd_w-1:0] digit,
    input logic               cin
  );
    logic [c_bcd_w:0] result;
    if (!cin) begin
      result = {1'b0, digit};
    end else if (digit >= 4'd9) begin
      result = {1'b1, 4'd0};
    end else begin
      result = {1'b0, digit + 4'd1};
    end
    return result;
  endfunction

endpackage : seq_match_pkg
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module     : bcd_to_7seg
// Description: Combinational BCD digit to active-high 7-segment decoder.
//              Output order {a,b,c,d,e,f,g}; non-BCD codes blank the digit.
// Revision   : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
  import seq_match_pkg::*;
(
  input  logic [c_bcd_w-1:0] bcd,
  output logic [6:0]         seg
);

  // Decode one digit; default keeps the output defined for codes 10..15
  always_comb begin
    seg = c_seg_blank;
    case (bcd)
      4'd0:    seg = c_seg_0;
      4'd1:    seg = c_seg_1;
      4'd2:    seg = c_seg_2;
      4'd3:    seg = c_seg_3;
      4'd4:    seg = c_seg_4;
      4'd5:    seg = c_seg_5;
      4'd6:    seg = c_seg_6;
      4'd7:    seg = c_seg_7;
      4'd8:    seg = c_seg_8;
      4'd9:    seg = c_seg_9;
      default: seg = c_seg_blank;
    endcase
  end

endmodule : bcd_to_7seg
`default_nettype wire

// File: rtl/seq_match_counter.sv
`default_nettype none
// ============================================================================
// Module     : seq_match_counter
// Description: Serial bit-pattern detector with a Mealy match flag, a BCD
//              match counter with sticky overflow, and per-digit 7-segment
//              decode. Overlapping or restart-after-hit matching is chosen
//              by parameter.
// Revision   : 1.0 - initial release
// ============================================================================
module seq_match_counter
  import seq_match_pkg::*;
#(
  parameter int PAT_W   = 4,
  parameter     PATTERN = 4'b1110,
  parameter int DIGITS  = 2,
  parameter int OVERLAP = 1
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     in,
  input  logic                     en,
  input  logic                     clr,
  output logic                     out,
  output logic [c_bcd_w*DIGITS-1:0] count,
  output logic [7*DIGITS-1:0]      seg,
  output logic                     ovf
);

  localparam int                c_count_w  = c_bcd_w * DIGITS;
  localparam int                c_fill_w   = $clog2(PAT_W);
  localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(PAT_W - 1);
  localparam logic [PAT_W-1:0]  c_pattern  = PATTERN;

  // Parameter legality, rejected at elaboration
  generate
    if (PAT_W < 2 || PAT_W > 16) begin : g_chk_pat_w
      $error("seq_match_counter: PAT_W must be in 2..16");
    end
    if (DIGITS < 1 || DIGITS > 4) begin : g_chk_digits
      $error("seq_match_counter: DIGITS must be in 1..4");
    end
    if ($bits(PATTERN) != PAT_W) begin : g_chk_pattern
      $error("seq_match_counter: PATTERN width must equal PAT_W");
    end
    if (OVERLAP != 0 && OVERLAP != 1) begin : g_chk_overlap
      $error("seq_match_counter: OVERLAP must be 0 or 1");
    end
  endgenerate

  logic [PAT_W-2:0]     r_history;
  logic [c_fill_w-1:0]  r_fill;
  logic [c_count_w-1:0] r_count;
  logic                 r_ovf;

  logic [PAT_W-1:0]     w_window;
  logic                 w_full;
  logic [c_count_w-1:0] w_count_next;
  logic                 w_wrap;

  // Newest bit joins the history as the LSB of the comparison window
  assign w_window = {r_history, in};
  assign w_full   = (r_fill == c_fill_max);
  assign out      = en & w_full & (w_window == c_pattern);

  assign count = r_count;
  assign ovf   = r_ovf;

  // Ripple-carry BCD increment of the count, carry-in is the match flag
  always_comb begin : p_bcd_inc
    logic [c_bcd_w:0] v_step;
    logic             v_carry;
    v_step       = '0;
    v_carry      = out;
    w_count_next = r_count;
    for (int d = 0; d < DIGITS; d++) begin
      v_step  = bcd_digit_inc(r_count[d*c_bcd_w +: c_bcd_w], v_carry);
      w_count_next[d*c_bcd_w +: c_bcd_w] = v_step[c_bcd_w-1:0];
      v_carry = v_step[c_bcd_w];
    end
    w_wrap = v_carry;
  end

  // Shift history and advance the fill level on every accepted bit
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (en) begin
      r_history <= w_window[PAT_W-2:0];
      if (OVERLAP == 0 && out) begin
        // Restart mode: the bits of this hit cannot seed the next one
        r_fill <= '0;
      end else if (!w_full) begin
        r_fill <= r_fill + c_fill_w'(1);
      end
    end
  end

  // Match counter with sticky wrap flag; clear wins over a same-cycle hit
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (out) begin
      r_count <= w_count_next;
      if (w_wrap) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // One decoder per BCD digit
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_to_7seg u_dec (
        .bcd (r_count[g*c_bcd_w +: c_bcd_w]),
        .seg (seg[g*7 +: 7])
      );
    end
  endgenerate

endmodule : seq_match_counter
`default_nettype wire

// File: tb/tb_seq_match_counter.sv
`default_nettype none
// ============================================================================
// Module     : tb_seq_match_counter
// Description: Directed self-checking bench for seq_match_counter. Three
//              instances share stimulus: defaults, PATTERN=1010 overlapping,
//              PATTERN=1010 restart-after-hit.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_seq_match_counter;

  logic CLK;
  logic reset;
  logic in;
  logic en;
  logic clr;

  logic        out_d,   out_o1,   out_o0;
  logic [7:0]  count_d, count_o1, count_o0;
  logic [13:0] seg_d,   seg_o1,   seg_o0;
  logic        ovf_d,   ovf_o1,   ovf_o0;

  int checks = 0;
  int errors = 0;

  logic last_d, last_o1, last_o0;

  localparam logic [13:0] SEG_00 = {7'b1111110, 7'b1111110};

  seq_match_counter dut_d (
    .CLK(CLK), .reset(reset), .in(in), .en(en), .clr(clr),
    .out(out_d), .count(count_d), .seg(seg_d), .ovf(ovf_d)
  );

  seq_match_counter #(.PAT_W(4), .PATTERN(4'b1010), .DIGITS(2), .OVERLAP(1)) dut_o1 (
    .CLK(CLK), .reset(reset), .in(in), .en(en), .clr(clr),
    .out(out_o1), .count(count_o1), .seg(seg_o1), .ovf(ovf_o1)
  );

  seq_match_counter #(.PAT_W(4), .PATTERN(4'b1010), .DIGITS(2), .OVERLAP(0)) dut_o0 (
    .CLK(CLK), .reset(reset), .in(in), .en(en), .clr(clr),
    .out(out_o0), .count(count_o0), .seg(seg_o0), .ovf(ovf_o0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle: inputs set at negedge, out captured mid low phase,
  // state observable 1 time unit after the rising edge.
  task automatic step(input logic b, input logic e, input logic c);
    @(negedge CLK);
    in  = b;
    en  = e;
    clr = c;
    #2;
    last_d  = out_d;
    last_o1 = out_o1;
    last_o0 = out_o0;
    @(posedge CLK);
    #1;
    en  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    #2;
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic send_match();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; in = 1'b1; en = 1'b1; clr = 1'b0;
    #3;
    checks++;
    if (out_d !== 1'b0) begin
      errors++; $display("FAIL reset_out got %b want 0", out_d);
    end
    checks++;
    if (count_d !== 8'h00 || ovf_d !== 1'b0) begin
      errors++; $display("FAIL reset_count got %h/%b want 00/0", count_d, ovf_d);
    end
    checks++;
    if (seg_d !== SEG_00) begin
      errors++; $display("FAIL reset_seg got %b want %b", seg_d, SEG_00);
    end
    @(posedge CLK); #1;
    checks++;
    if (count_d !== 8'h00) begin
      errors++; $display("FAIL reset_hold got %h want 00", count_d);
    end
    en = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_single_match();
    logic [3:0] pulses;
    do_reset();
    pulses = '0;
    step(1'b1, 1'b1, 1'b0); pulses[0] = last_d;
    step(1'b1, 1'b1, 1'b0); pulses[1] = last_d;
    step(1'b1, 1'b1, 1'b0); pulses[2] = last_d;
    step(1'b0, 1'b1, 1'b0); pulses[3] = last_d;
    checks++;
    if (pulses !== 4'b1000) begin
      errors++; $display("FAIL single_out got %b want 1000", pulses);
    end
    checks++;
    if (count_d !== 8'h01) begin
      errors++; $display("FAIL single_count got %h want 01", count_d);
    end
    checks++;
    if (seg_d[6:0] !== 7'b0110000 || seg_d[13:7] !== 7'b1111110) begin
      errors++; $display("FAIL single_seg got %b want 11111100110000", seg_d);
    end
  endtask

  task automatic test_overlap_stream();
    logic [10:0] bits;
    int          pulses;
    bits = 11'b11111101110;
    do_reset();
    pulses = 0;
    for (int i = 10; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0);
      if (last_d) pulses++;
    end
    checks++;
    if (pulses != 2 || count_d !== 8'h02) begin
      errors++; $display("FAIL stream_pulses got %0d/%h want 2/02", pulses, count_d);
    end
    do_reset();
    pulses = 0;
    for (int i = 10; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0);
      if (last_d) pulses++;
      step(1'b0, 1'b0, 1'b0);
      if (last_d) pulses++;
    end
    checks++;
    if (pulses != 2 || count_d !== 8'h02) begin
      errors++; $display("FAIL stream_gapped got %0d/%h want 2/02", pulses, count_d);
    end
  endtask

  task automatic test_overlap_mode();
    logic [5:0] bits;
    bits = 6'b101010;
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0);
    end
    checks++;
    if (count_o1 !== 8'h02) begin
      errors++; $display("FAIL overlap1_count got %h want 02", count_o1);
    end
    checks++;
    if (count_o0 !== 8'h01) begin
      errors++; $display("FAIL overlap0_count got %h want 01", count_o0);
    end
  endtask

  task automatic test_wrap_and_clear();
    do_reset();
    for (int n = 1; n <= 100; n++) begin
      send_match();
      if (n == 10) begin
        checks++;
        if (count_d !== 8'h10 || seg_d !== {7'b0110000, 7'b1111110}) begin
          errors++; $display("FAIL carry10 got %h/%b want 10", count_d, seg_d);
        end
      end
      if (n == 99) begin
        checks++;
        if (count_d !== 8'h99 || ovf_d !== 1'b0 || seg_d !== {7'b1110011, 7'b1110011}) begin
          errors++; $display("FAIL at99 got %h/%b want 99/0", count_d, ovf_d);
        end
      end
    end
    checks++;
    if (count_d !== 8'h00 || ovf_d !== 1'b1) begin
      errors++; $display("FAIL wrap got %h/%b want 00/1", count_d, ovf_d);
    end
    send_match();
    checks++;
    if (count_d !== 8'h01 || ovf_d !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %h/%b want 01/1", count_d, ovf_d);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (last_d !== 1'b1 || count_d !== 8'h00 || ovf_d !== 1'b0) begin
      errors++; $display("FAIL clr_with_match got out=%b %h/%b want 1 00/0", last_d, count_d, ovf_d);
    end
    send_match();
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (count_d !== 8'h00) begin
      errors++; $display("FAIL clr_no_en got %h want 00", count_d);
    end
  endtask

  task automatic test_reset_mid_pattern();
    do_reset();
    send_match();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (count_d !== 8'h00 || seg_d !== SEG_00 || out_d !== 1'b0) begin
      errors++; $display("FAIL async_reset got %h/%b/%b want 00", count_d, seg_d, out_d);
    end
    #1;
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (last_d !== 1'b0 || count_d !== 8'h00 || seg_d !== SEG_00) begin
      errors++; $display("FAIL mid_reset_discard got out=%b %h want 0 00", last_d, count_d);
    end
    send_match();
    checks++;
    if (last_d !== 1'b1 || count_d !== 8'h01) begin
      errors++; $display("FAIL fresh_match got out=%b %h want 1 01", last_d, count_d);
    end
  endtask

  initial begin
    in = 1'b0; en = 1'b0; clr = 1'b0; reset = 1'b0;
    last_d = 1'b0; last_o1 = 1'b0; last_o0 = 1'b0;
    test_reset();
    test_single_match();
    test_overlap_stream();
    test_overlap_mode();
    test_wrap_and_clear();
    test_reset_mid_pattern();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_match_counter
`default_nettype wire
